cube_scan_sequencer: RTL and testbench
======================================

# cube_scan_sequencer

Layer-multiplexing scan controller for the 8×8×8 LED cube. It holds a double-buffered frame (two banks × 8 layers × 64 columns) written by the UART/Avalon side. It serially shifts each layer's 64 column bits into the external column shift-register chain over GPIO_0, then drives the one-hot layer enables, with blanking between layers. Bank swaps are requested by software and take effect only at frame boundaries, so the displayed frame never tears.

## Interface
- CLK_DIV, 2: clk cycles per shift-clock half-period (≥1)
- BLANK_CYCLES, 16: all-off cycles before each latch (≥1)
- ON_CYCLES, 5000: cycles a layer is lit before the next LOAD (≥1)
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  scanning enabled
- wr_en  in  1  write one layer word into the back bank
- wr_layer  in  3  layer index for the write
- wr_data  in  64  column bits for that layer; bit i = column i
- swap_req  in  1  request front/back swap at the next frame end (level or pulse)
- swap_ack  out  1  one-cycle pulse on the cycle the swap occurs
- frame_done  out  1  one-cycle pulse at the end of layer 7's ON
- sr_data  out  1  serial column data
- sr_clk  out  1  shift clock; data shifts on rising edge
- sr_latch  out  1  storage-register latch pulse
- sr_oe_n  out  1  column driver output enable, active low
- layer_en  out  8  one-hot layer drive
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Banks: bank_sel selects the front (displayed) bank; the back bank is !bank_sel. Memory is not reset.
- Writes: wr_en writes wr_data into back[wr_layer] every cycle it is asserted, in any state. A write on the swap cycle uses the pre-swap bank_sel, so it lands in the bank becoming front.
- swap_pend is set by swap_req and cleared on swap. Multiple requests within one frame produce one swap.
- FSM states: IDLE, LOAD, SHIFT, BLANK, LATCH, ON.
- IDLE: layer=0, layer_en=0, sr_oe_n=1. Goes to LOAD when enable=1.
- LOAD (1 cycle): shreg ← front[layer].
- SHIFT: 64 bits, bit 63 first. Per bit: sr_data=current bit, sr_clk=0 for CLK_DIV cycles, then sr_clk=1 for CLK_DIV cycles. The previous layer stays lit during SHIFT.
- BLANK (BLANK_CYCLES): layer_en=0, sr_oe_n=1.
- LATCH (1 cycle): sr_latch=1, still blanked.
- ON (ON_CYCLES): layer_en=1<<layer, sr_oe_n=0.
- ON exit:
  - If layer=7: pulse frame_done. If swap_pend, toggle bank_sel and pulse swap_ack in that same cycle. Set layer=0.
  - Otherwise: layer+1.
  - Then go to LOAD, or to IDLE if enable=0. IDLE entry clears layer_en and sets sr_oe_n=1 on the next cycle.
- enable deasserted outside ON: the scan continues until the end of the current layer's ON.
- Counters: the bit counter is 7 bits and the cycle counter is wide enough for max(ON_CYCLES, BLANK_CYCLES, CLK_DIV). There is no wrap except layer 7→0.

## Timing
- Reset values: state IDLE, layer 0, bank_sel 0, swap_pend 0, sr_data 0, sr_clk 0, sr_latch 0, sr_oe_n 1, layer_en 0, swap_ack 0, frame_done 0, busy 0.
- Reset asserts mid-operation: outputs go to their reset values immediately (asynchronous).
- enable=1 in IDLE: LOAD on the next cycle. The first sr_clk rise occurs CLK_DIV cycles after SHIFT entry.
- Layer period = 1 + 128·CLK_DIV + BLANK_CYCLES + 1 + ON_CYCLES cycles.
- Frame period = 8 × layer period.
- Lit time per layer (steady state) = ON_CYCLES + 1 + 128·CLK_DIV.
- sr_data changes only while sr_clk=0. Setup is ≥ CLK_DIV cycles, hold is ≥ CLK_DIV cycles.
- swap_ack and frame_done are coincident single-cycle pulses. swap_ack occurs only when frame_done occurs.

## Test plan
- Reset: assert reset mid-ON (CLK_DIV=2, BLANK_CYCLES=4, ON_CYCLES=20) -> layer_en=0x00, sr_oe_n=1, busy=0 immediately; no sr_clk edges while reset is held.
- Single pixel: write back[0]=0x8000_0000_0000_0001, pulse swap_req, enable=1 -> swap_ack at the first frame end. In frame 2, layer 0 sees 64 sr_clk rises with sr_data=1,0×62,1, then sr_latch high 1 cycle after 4 blank cycles, then layer_en=0x01 for 20 cycles.
- Sequencing: enable held -> layer_en walks 0x01,0x02,…,0x80. frame_done pulses every 8×282=2256 cycles. Layer 7 is followed by 0x01.
- Swap timing: swap_req held 5 cycles mid-layer 3 -> exactly one swap_ack, at the end of layer 7's ON. New data appears from the next layer-0 SHIFT. No swap occurs without a request.
- Write-during-swap: wr_en on the swap_ack cycle to layer 2 -> the data is displayed in the frame that starts immediately after.
- Disable: drop enable during SHIFT of layer 4 -> layer 4 completes ON (20 cycles) -> IDLE, layer_en=0, busy=0. Re-enable -> restarts at layer 0.

Source files
------------

// File: rtl/cube_scan_sequencer_if.sv
// Bus bundle for the LED-cube scan sequencer.
// slave  : the sequencer side (takes frame writes and control, drives the scan outputs).
// master : the host/bench side.
// Signals: enable, wr_en, wr_layer[2:0], wr_data[63:0], swap_req (host -> sequencer)
//          swap_ack, frame_done, sr_data, sr_clk, sr_latch, sr_oe_n,
//          layer_en[7:0], busy (sequencer -> host)
interface cube_scan_sequencer_if;
  logic        enable;
  logic        wr_en;
  logic [2:0]  wr_layer;
  logic [63:0] wr_data;
  logic        swap_req;
  logic        swap_ack;
  logic        frame_done;
  logic        sr_data;
  logic        sr_clk;
  logic        sr_latch;
  logic        sr_oe_n;
  logic [7:0]  layer_en;
  logic        busy;

  modport slave (
    input  enable, wr_en, wr_layer, wr_data, swap_req,
    output swap_ack, frame_done, sr_data, sr_clk, sr_latch, sr_oe_n, layer_en, busy
  );

  modport master (
    output enable, wr_en, wr_layer, wr_data, swap_req,
    input  swap_ack, frame_done, sr_data, sr_clk, sr_latch, sr_oe_n, layer_en, busy
  );
endinterface

// File: rtl/cube_scan_sequencer.sv
// Layer-multiplexing scan controller for an 8x8x8 LED cube.
// Holds a double-buffered frame (2 banks x 8 layers x 64 columns), shifts each
// layer's columns MSB-first into the external column shift-register chain, then
// blanks, latches and lights that layer. Bank swaps only happen at frame end.
// Ports:
//   i_clk   : system clock
//   i_reset : asynchronous active-high reset
//   io_bus  : cube_scan_sequencer_if.slave (writes, swap request, scan outputs)
module cube_scan_sequencer #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned ON_CYCLES    = 5000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  cube_scan_sequencer_if.slave io_bus
);

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned N_LAYERS = 8;
  localparam int unsigned LAYER_W  = 3;
  localparam int unsigned BIT_W    = 7;
  localparam int unsigned PERIOD   = 2 * CLK_DIV;
  localparam int unsigned MAX_OB   = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_MAX  = (MAX_OB > PERIOD) ? MAX_OB : PERIOD;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_RISE      = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_END   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ON_END    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ON_PRE    = CNT_W'((ON_CYCLES >= 2) ? (ON_CYCLES - 2) : 0);
  localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(DATA_W - 1);
  localparam logic [LAYER_W-1:0] LAYER_LAST  = LAYER_W'(N_LAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_BLANK, S_LATCH, S_ON
  } state_t;

  state_t               r_state;
  logic [LAYER_W-1:0]   r_layer;
  logic                 r_bank_sel;
  logic                 r_swap_pend;
  logic [DATA_W-1:0]    r_shreg;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sr_data;
  logic                 r_sr_clk;
  logic                 r_sr_latch;
  logic                 r_sr_oe_n;
  logic [N_LAYERS-1:0]  r_layer_en;
  logic                 r_swap_ack;
  logic                 r_frame_done;
  logic                 r_busy;
  logic [DATA_W-1:0]    r_mem [2][N_LAYERS];

  logic                 w_last_layer;
  logic                 w_pend;

  assign w_last_layer = (r_layer == LAYER_LAST);
  // A request arriving in the cycle the pulses are armed still makes this frame.
  assign w_pend       = r_swap_pend | io_bus.swap_req;

  // Frame store: writes always target the back bank; not reset.
  always_ff @(posedge i_clk) begin
    if (io_bus.wr_en) begin
      r_mem[~r_bank_sel][io_bus.wr_layer] <= io_bus.wr_data;
    end
  end

  // Scan sequencer. frame_done/swap_ack are armed one cycle early so they are
  // high during layer 7's last ON cycle, the same cycle whose closing edge swaps.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_layer      <= '0;
      r_bank_sel   <= 1'b0;
      r_swap_pend  <= 1'b0;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_cnt        <= '0;
      r_sr_data    <= 1'b0;
      r_sr_clk     <= 1'b0;
      r_sr_latch   <= 1'b0;
      r_sr_oe_n    <= 1'b1;
      r_layer_en   <= '0;
      r_swap_ack   <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      if (io_bus.swap_req) r_swap_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_layer    <= '0;
          r_layer_en <= '0;
          r_sr_oe_n  <= 1'b1;
          r_sr_clk   <= 1'b0;
          r_sr_data  <= 1'b0;
          if (io_bus.enable) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end

        S_LOAD: begin
          r_shreg   <= r_mem[r_bank_sel][r_layer];
          r_sr_data <= r_mem[r_bank_sel][r_layer][DATA_W-1];
          r_sr_clk  <= 1'b0;
          r_bit_cnt <= '0;
          r_cnt     <= '0;
          r_state   <= S_SHIFT;
        end

        // Each bit: CLK_DIV cycles low (data settles), CLK_DIV cycles high.
        S_SHIFT: begin
          if (r_cnt == CNT_BIT_END) begin
            r_cnt     <= '0;
            r_sr_clk  <= 1'b0;
            r_shreg   <= {r_shreg[DATA_W-2:0], 1'b0};
            r_sr_data <= r_shreg[DATA_W-2];
            if (r_bit_cnt == BIT_LAST) begin
              r_state    <= S_BLANK;
              r_sr_data  <= 1'b0;
              r_layer_en <= '0;
              r_sr_oe_n  <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end else begin
            if (r_cnt == CNT_RISE) r_sr_clk <= 1'b1;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_BLANK: begin
          if (r_cnt == CNT_BLANK_END) begin
            r_cnt      <= '0;
            r_sr_latch <= 1'b1;
            r_state    <= S_LATCH;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_LATCH: begin
          r_sr_latch <= 1'b0;
          r_layer_en <= N_LAYERS'(1) << r_layer;
          r_sr_oe_n  <= 1'b0;
          r_cnt      <= '0;
          r_state    <= S_ON;
          if (ON_CYCLES == 1 && w_last_layer) begin
            r_frame_done <= 1'b1;
            r_swap_ack   <= w_pend;
          end
        end

        S_ON: begin
          if (r_cnt == CNT_ON_END) begin
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
            r_swap_ack   <= 1'b0;
            if (r_swap_ack) begin
              r_bank_sel  <= ~r_bank_sel;
              r_swap_pend <= io_bus.swap_req;
            end
            r_layer <= r_layer + LAYER_W'(1);
            if (io_bus.enable) begin
              r_state <= S_LOAD;
            end else begin
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
              r_layer    <= '0;
              r_layer_en <= '0;
              r_sr_oe_n  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_ON_PRE && w_last_layer) begin
              r_frame_done <= 1'b1;
              r_swap_ack   <= w_pend;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.sr_data    = r_sr_data;
  assign io_bus.sr_clk     = r_sr_clk;
  assign io_bus.sr_latch   = r_sr_latch;
  assign io_bus.sr_oe_n    = r_sr_oe_n;
  assign io_bus.layer_en   = r_layer_en;
  assign io_bus.swap_ack   = r_swap_ack;
  assign io_bus.frame_done = r_frame_done;
  assign io_bus.busy       = r_busy;

endmodule

// File: tb/tb_cube_scan_sequencer.sv
// Self-checking bench for cube_scan_sequencer (CLK_DIV=2, BLANK_CYCLES=4, ON_CYCLES=20).
// Expected scan behaviour is derived from the cycle offset within a layer/frame.
module tb_cube_scan_sequencer;
  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned BLANK   = 4;
  localparam int unsigned ON      = 20;
  localparam int L       = 1 + 128*CLK_DIV + BLANK + 1 + ON;  // 282
  localparam int F       = 8 * L;                            // 2256
  localparam int P_BLANK = 1 + 128*CLK_DIV;                  // 257
  localparam int P_LATCH = P_BLANK + BLANK;                  // 261
  localparam int P_ON    = P_LATCH + 1;                      // 262

  logic clk = 1'b0;
  logic rst;
  cube_scan_sequencer_if bus();

  cube_scan_sequencer #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK), .ON_CYCLES(ON)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .io_bus (bus)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference frame store.
  logic [63:0] m_mem [2][8];
  bit          m_val [2][8];
  bit          m_front;
  bit          m_pend;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.enable = 1'b0; bus.wr_en = 1'b0; bus.wr_layer = 3'd0;
    bus.wr_data = 64'd0; bus.swap_req = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    m_front = 1'b0;
    m_pend  = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] got;
    rst = 1'b1;
    bus.enable = 1'b0; bus.wr_en = 1'b0; bus.wr_layer = 3'd0;
    bus.wr_data = 64'd0; bus.swap_req = 1'b0;
    repeat (2) tick();
    got = {bus.layer_en, bus.sr_oe_n, bus.busy, bus.sr_clk, bus.sr_data, bus.sr_latch, bus.swap_ack};
    n_vec++;
    if (got !== {8'h00, 1'b1, 5'b00000}) begin
      n_err++; $display("FAIL reset_outputs got %b want %b", got, {8'h00, 1'b1, 5'b00000});
    end
    n_vec++;
    if (bus.frame_done !== 1'b0) begin
      n_err++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      got = {bus.layer_en, bus.sr_oe_n, bus.busy, bus.sr_clk, bus.sr_data, bus.sr_latch, bus.swap_ack};
      n_vec++;
      if (got !== {8'h00, 1'b1, 5'b00000}) begin
        n_err++; $display("FAIL idle_no_enable cyc=%0d got %b want %b", i, got, {8'h00, 1'b1, 5'b00000});
      end
    end
    m_front = 1'b0;
    m_pend  = 1'b0;
  endtask

  task automatic test_single_pixel();
    int          c;
    int          ack_c;
    int          rises;
    int          latch_at;
    int          lit;
    int          blanked;
    bit          prev_clk;
    logic [63:0] cap;
    do_reset();
    bus.wr_en = 1'b1; bus.wr_layer = 3'd0; bus.wr_data = 64'h8000_0000_0000_0001;
    m_mem[1][0] = 64'h8000_0000_0000_0001; m_val[1][0] = 1'b1;
    bus.swap_req = 1'b1; bus.enable = 1'b1;
    tick();                                  // c = 0 : LOAD of layer 0
    bus.wr_en = 1'b0; bus.swap_req = 1'b0;
    c = 0; ack_c = -1;
    while (c < F + 20 && ack_c < 0) begin
      tick(); c++;
      if (bus.swap_ack === 1'b1) ack_c = c;
    end
    n_vec++;
    if (ack_c != F - 1) begin
      n_err++; $display("FAIL pixel_swap_ack_cycle got %0d want %0d", ack_c, F - 1);
    end
    n_vec++;
    if (bus.frame_done !== 1'b1) begin
      n_err++; $display("FAIL pixel_frame_done_with_ack got %b want 1", bus.frame_done);
    end
    while (c < F) begin tick(); c++; end
    rises = 0; latch_at = -1; lit = 0; blanked = 0; prev_clk = 1'b0; cap = '0;
    for (int k = F + 1; k <= F + L - 1; k++) begin
      tick();
      if (k == F + 100) bus.enable = 1'b0;
      if (bus.sr_clk === 1'b1 && !prev_clk) begin rises++; cap = {cap[62:0], bus.sr_data}; end
      prev_clk = (bus.sr_clk === 1'b1);
      if (bus.sr_latch === 1'b1) latch_at = (latch_at < 0) ? k : -2;
      if (bus.layer_en === 8'h01 && bus.sr_oe_n === 1'b0) lit++;
      if (k >= F + P_BLANK && k <= F + P_LATCH && bus.layer_en === 8'h00 && bus.sr_oe_n === 1'b1) blanked++;
    end
    n_vec++;
    if (rises != 64) begin n_err++; $display("FAIL pixel_rises got %0d want 64", rises); end
    n_vec++;
    if (cap !== 64'h8000_0000_0000_0001) begin
      n_err++; $display("FAIL pixel_data got %h want 8000000000000001", cap);
    end
    n_vec++;
    if (latch_at != F + P_LATCH) begin
      n_err++; $display("FAIL pixel_latch got %0d want %0d", latch_at, F + P_LATCH);
    end
    n_vec++;
    if (blanked != BLANK + 1) begin n_err++; $display("FAIL pixel_blank got %0d want %0d", blanked, BLANK + 1); end
    n_vec++;
    if (lit != ON) begin n_err++; $display("FAIL pixel_lit got %0d want %0d", lit, ON); end
    tick();
    n_vec++;
    if ({bus.busy, bus.layer_en, bus.sr_oe_n} !== {1'b0, 8'h00, 1'b1}) begin
      n_err++; $display("FAIL pixel_idle got %b want %b", {bus.busy, bus.layer_en, bus.sr_oe_n}, {1'b0, 8'h00, 1'b1});
    end
  endtask

  task automatic test_scan_random();
    localparam int NF = 5;
    logic [63:0] snap;
    bit          snap_ok;
    logic [7:0]  e_en;
    bit          e_oe, e_clk, e_latch, e_fd, e_ack;
    logic [13:0] got, exp;
    int          p, lay, q, fr, cf;
    do_reset();
    bus.enable = 1'b1;
    tick();                                  // c = 0 : LOAD of layer 0
    snap = '0; snap_ok = 1'b0;
    for (int c = 0; c < NF * F; c++) begin
      if (c > 0) tick();
      p = c % L; lay = (c / L) % 8; fr = c / F; cf = c % F;
      if (p == 0) begin snap = m_mem[m_front][lay]; snap_ok = m_val[m_front][lay]; end
      e_en = 8'h00; e_oe = 1'b1;
      if (p >= P_ON) begin e_en = 8'h01 << lay; e_oe = 1'b0; end
      else if (p < P_BLANK && c >= L) begin e_en = 8'h01 << ((lay + 7) % 8); e_oe = 1'b0; end
      e_clk   = (p >= 1 && p < P_BLANK) && (((p - 1) % (2 * CLK_DIV)) >= CLK_DIV);
      e_latch = (p == P_LATCH);
      e_fd    = (cf == F - 1);
      e_ack   = e_fd && m_pend;
      got = {bus.layer_en, bus.sr_oe_n, bus.sr_clk, bus.sr_latch, bus.frame_done, bus.swap_ack, bus.busy};
      exp = {e_en, e_oe, e_clk, e_latch, e_fd, e_ack, 1'b1};
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL scan_ctrl c=%0d got %b want %b", c, got, exp);
      end
      if (p >= 1 && p < P_BLANK && snap_ok) begin
        q = (p - 1) / (2 * CLK_DIV);
        n_vec++;
        if (bus.sr_data !== snap[63 - q]) begin
          n_err++; $display("FAIL scan_data c=%0d layer=%0d bit=%0d got %b want %b", c, lay, 63 - q, bus.sr_data, snap[63 - q]);
        end
      end
      // Stimulus for this cycle.
      bus.wr_en = 1'b0; bus.swap_req = 1'b0;
      if (e_ack) begin
        bus.wr_en = 1'b1; bus.wr_layer = 3'd2; bus.wr_data = {$urandom, $urandom};
      end else if (fr == 0 && c < 8) begin
        bus.wr_en = 1'b1; bus.wr_layer = 3'(c); bus.wr_data = {$urandom, $urandom};
      end else if ($urandom_range(63) == 0) begin
        bus.wr_en = 1'b1; bus.wr_layer = 3'($urandom_range(7)); bus.wr_data = {$urandom, $urandom};
      end
      if (fr == 0 && c == 10) bus.swap_req = 1'b1;
      if (fr == 1 && cf >= 3 * L + 100 && cf < 3 * L + 105) bus.swap_req = 1'b1;
      if (fr == 3 && cf < F - 2 && $urandom_range(499) == 0) bus.swap_req = 1'b1;
      if (c == NF * F - 10) bus.enable = 1'b0;
      // Model update: write lands in the pre-swap back bank, then the swap.
      if (bus.wr_en) begin
        m_mem[!m_front][bus.wr_layer] = bus.wr_data;
        m_val[!m_front][bus.wr_layer] = 1'b1;
      end
      if (e_ack) begin m_front = !m_front; m_pend = bus.swap_req; end
      else if (bus.swap_req) m_pend = 1'b1;
    end
    bus.wr_en = 1'b0; bus.swap_req = 1'b0;
    tick();
    n_vec++;
    if ({bus.busy, bus.layer_en, bus.sr_oe_n} !== {1'b0, 8'h00, 1'b1}) begin
      n_err++; $display("FAIL scan_stop_idle got %b want %b", {bus.busy, bus.layer_en, bus.sr_oe_n}, {1'b0, 8'h00, 1'b1});
    end
  endtask

  task automatic test_disable();
    int lit4;
    int busy_lost;
    do_reset();
    bus.enable = 1'b1;
    tick();                                  // c = 0
    lit4 = 0; busy_lost = 0;
    for (int c = 1; c <= 5 * L - 1; c++) begin
      tick();
      if (c == 4 * L + 50) bus.enable = 1'b0;
      if (c >= 4 * L + P_ON && bus.layer_en === 8'h10 && bus.sr_oe_n === 1'b0) lit4++;
      if (bus.busy !== 1'b1) busy_lost++;
    end
    n_vec++;
    if (lit4 != ON) begin n_err++; $display("FAIL disable_layer4_on got %0d want %0d", lit4, ON); end
    n_vec++;
    if (busy_lost != 0) begin n_err++; $display("FAIL disable_busy_drop got %0d want 0", busy_lost); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({bus.busy, bus.layer_en, bus.sr_oe_n, bus.sr_clk} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
        n_err++; $display("FAIL disable_idle i=%0d got %b want %b", i,
                          {bus.busy, bus.layer_en, bus.sr_oe_n, bus.sr_clk}, {1'b0, 8'h00, 1'b1, 1'b0});
      end
    end
    bus.enable = 1'b1;
    tick();                                  // c = 0 : LOAD of layer 0 again
    for (int c = 1; c <= P_ON; c++) begin
      tick();
      if (c == P_ON - 1) begin
        n_vec++;
        if (bus.layer_en !== 8'h00) begin
          n_err++; $display("FAIL restart_blank got %h want 00", bus.layer_en);
        end
      end
    end
    n_vec++;
    if (bus.layer_en !== 8'h01) begin n_err++; $display("FAIL restart_layer0 got %h want 01", bus.layer_en); end
    bus.enable = 1'b0;
  endtask

  task automatic test_reset_mid_on();
    int c;
    int rises;
    bit prev_clk;
    do_reset();
    bus.enable = 1'b1;
    tick();
    c = 0;
    while (c < 1000 && bus.layer_en === 8'h00) begin tick(); c++; end
    n_vec++;
    if (c != P_ON) begin n_err++; $display("FAIL rst_first_on got %0d want %0d", c, P_ON); end
    repeat (5) tick();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.layer_en, bus.sr_oe_n, bus.busy} !== {8'h00, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL rst_async got %b want %b", {bus.layer_en, bus.sr_oe_n, bus.busy}, {8'h00, 1'b1, 1'b0});
    end
    rises = 0; prev_clk = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.sr_clk === 1'b1 && !prev_clk) rises++;
      prev_clk = (bus.sr_clk === 1'b1);
    end
    n_vec++;
    if (rises != 0 || bus.layer_en !== 8'h00) begin
      n_err++; $display("FAIL rst_hold got rises=%0d en=%h want rises=0 en=00", rises, bus.layer_en);
    end
    bus.enable = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0; bus.wr_en = 1'b0; bus.wr_layer = 3'd0;
    bus.wr_data = 64'd0; bus.swap_req = 1'b0;
    m_front = 1'b0; m_pend = 1'b0;
    test_reset();
    test_single_pixel();
    test_scan_random();
    test_disable();
    test_reset_mid_on();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
